// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier datapath.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    localparam int unsigned MAX_W = 64;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Canonical quiet NaN: positive, all-ones exponent, only the fraction MSB set.
    function automatic logic [MAX_W-1:0] qnan(input int unsigned exp_w, input int unsigned frac_w);
        logic [MAX_W-1:0] r;
        r = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << frac_w;
        r = r | (MAX_W'(1) << (frac_w - 32'd1));
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_round_norm.sv
// Combinational normalise, round-to-nearest-even, pack and flag generation
// for a raw significand product; shared with the planned adder.
module fp_round_norm
    import fp_mul_pkg::*;
#(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                     sign,
    input  logic signed [EXP_W+1:0]  exp_in,
    input  logic [2*FRAC_W+1:0]      prod,
    output logic [EXP_W+FRAC_W:0]    result,
    output fp_flags_t                flags
);

    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned MW = FRAC_W + 1;
    localparam int unsigned PW = 2 * FRAC_W + 2;
    localparam logic signed [EW-1:0] EXP_OVF = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

    logic                 norm;
    logic [PW-1:0]        sh;
    logic [MW-1:0]        mant;
    logic                 guard;
    logic                 rnd;
    logic                 sticky;
    logic                 round_up;
    logic [MW:0]          mant_r;
    logic                 carry;
    logic [FRAC_W-1:0]    frac;
    logic signed [EW-1:0] exp_f;

    always_comb begin
        // Align so the hidden bit sits in the product MSB.
        norm     = prod[PW-1];
        sh       = norm ? prod : (prod << 1);
        mant     = sh[PW-1 -: MW];
        guard    = sh[FRAC_W];
        rnd      = sh[FRAC_W-1];
        sticky   = |sh[FRAC_W-2:0];
        round_up = guard & (rnd | sticky | mant[0]);
        mant_r   = {1'b0, mant} + (MW+1)'(round_up);
        carry    = mant_r[MW];
        frac     = carry ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];
        exp_f    = exp_in + EW'(norm) + EW'(carry);

        flags         = '0;
        flags.inexact = guard | rnd | sticky;
        result        = {sign, exp_f[EXP_W-1:0], frac};

        if (exp_f >= EXP_OVF) begin
            result         = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            flags.overflow = 1'b1;
            flags.inexact  = 1'b1;
        end else if (exp_f < EXP_ONE) begin
            result          = {sign, {(EXP_W+FRAC_W){1'b0}}};
            flags.underflow = 1'b1;
            flags.inexact   = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready on both
// sides; the whole pipe advances or stalls as one unit.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter  int unsigned EXP_W  = 8,
    parameter  int unsigned FRAC_W = 23,
    localparam int unsigned W      = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned MW = FRAC_W + 1;
    localparam int unsigned PW = 2 * MW;
    localparam logic signed [EW-1:0] BIAS = EW'(bias(EXP_W));
    localparam logic [W-1:0] QNAN = W'(qnan(EXP_W, FRAC_W));

    function automatic fp_class_e class_of(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
        if (e == '1) return (f != '0) ? FP_NAN : FP_INF;
        if (e == '0) return FP_ZERO;
        return FP_NORM;
    endfunction

    logic advance;

    logic [EXP_W-1:0]     ea, eb;
    logic [FRAC_W-1:0]    fa, fb;
    fp_class_e            ca, cb;
    logic                 u_sign;
    logic signed [EW-1:0] u_exp;
    logic                 u_spec;
    logic [W-1:0]         u_spec_res;
    fp_flags_t            u_spec_flags;

    logic                 s1_valid;
    logic                 s1_sign;
    logic signed [EW-1:0] s1_exp;
    logic [MW-1:0]        s1_ma, s1_mb;
    logic                 s1_spec;
    logic [W-1:0]         s1_spec_res;
    fp_flags_t            s1_spec_flags;

    logic                 s2_valid;
    logic                 s2_sign;
    logic signed [EW-1:0] s2_exp;
    logic [PW-1:0]        s2_prod;
    logic                 s2_spec;
    logic [W-1:0]         s2_spec_res;
    fp_flags_t            s2_spec_flags;

    logic [W-1:0]         rn_result;
    fp_flags_t            rn_flags;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Unpack and classify; denormals read as zero because exp == 0.
    always_comb begin
        ea           = a[W-2 -: EXP_W];
        eb           = b[W-2 -: EXP_W];
        fa           = a[FRAC_W-1:0];
        fb           = b[FRAC_W-1:0];
        ca           = class_of(ea, fa);
        cb           = class_of(eb, fb);
        u_sign       = a[W-1] ^ b[W-1];
        u_exp        = EW'(ea) + EW'(eb) - BIAS;
        u_spec       = 1'b1;
        u_spec_res   = '0;
        u_spec_flags = '0;
        if (ca == FP_NAN || cb == FP_NAN ||
            (ca == FP_ZERO && cb == FP_INF) || (ca == FP_INF && cb == FP_ZERO)) begin
            u_spec_res           = QNAN;
            u_spec_flags.invalid = 1'b1;
        end else if (ca == FP_INF || cb == FP_INF) begin
            u_spec_res = {u_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (ca == FP_ZERO || cb == FP_ZERO) begin
            u_spec_res = {u_sign, {(W-1){1'b0}}};
        end else begin
            u_spec = 1'b0;
        end
    end

    fp_round_norm #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round_norm (
        .sign   (s2_sign),
        .exp_in (s2_exp),
        .prod   (s2_prod),
        .result (rn_result),
        .flags  (rn_flags)
    );

    // Pipeline registers: every stage moves only when the output side can drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_exp        <= '0;
            s1_ma         <= '0;
            s1_mb         <= '0;
            s1_spec       <= 1'b0;
            s1_spec_res   <= '0;
            s1_spec_flags <= '0;
            s2_valid      <= 1'b0;
            s2_sign       <= 1'b0;
            s2_exp        <= '0;
            s2_prod       <= '0;
            s2_spec       <= 1'b0;
            s2_spec_res   <= '0;
            s2_spec_flags <= '0;
            out_valid     <= 1'b0;
            result        <= '0;
            flags         <= '0;
        end else if (advance) begin
            s1_valid      <= in_valid;
            s1_sign       <= u_sign;
            s1_exp        <= u_exp;
            s1_ma         <= {1'b1, fa};
            s1_mb         <= {1'b1, fb};
            s1_spec       <= u_spec;
            s1_spec_res   <= u_spec_res;
            s1_spec_flags <= u_spec_flags;

            s2_valid      <= s1_valid;
            s2_sign       <= s1_sign;
            s2_exp        <= s1_exp;
            s2_prod       <= PW'(s1_ma) * PW'(s1_mb);
            s2_spec       <= s1_spec;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;

            out_valid     <= s2_valid;
            result        <= s2_spec ? s2_spec_res : rn_result;
            flags         <= s2_spec ? s2_spec_flags : rn_flags;
        end
    end

endmodule
